// File: rtl/demux2_stream_pkg.sv
// Shared constants and types for the two-way stream demultiplexer.
package demux2_stream_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned COUNT_W    = 2;
    localparam int unsigned PTR_W      = 1;

    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [PTR_W-1:0]   ptr_t;

    localparam count_t COUNT_FULL = count_t'(FIFO_DEPTH);

    // Pointers index a 2-entry array, so advancing is a modulo-2 increment.
    function automatic ptr_t ptr_next(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/demux2_stream_fifo2.sv
// Two-entry valid/ready FIFO; output word is read straight from the storage registers.
module stream_fifo2
    import demux2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    count_t           count;
    logic             push;
    logic             pop;

    // Readiness looks only at the stored count, so a full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign push_ready = (count < COUNT_FULL);
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];

    assign push = push_valid & push_ready;
    assign pop  = pop_valid & pop_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + count_t'(push) - count_t'(pop);
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// Routes one valid/ready input stream to one of two buffered output streams by I_sel.
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_sel,
    output logic             O0_valid,
    input  logic             O0_ready,
    output logic [WIDTH-1:0] O0_data,
    output logic             O1_valid,
    input  logic             O1_ready,
    output logic [WIDTH-1:0] O1_data
);

    logic push0_valid;
    logic push1_valid;
    logic push0_ready;
    logic push1_ready;

    assign push0_valid = I_valid & ~I_sel;
    assign push1_valid = I_valid &  I_sel;

    // Only the selected FIFO's occupancy gates the input; downstream ready never does.
    assign I_ready = I_sel ? push1_ready : push0_ready;

    stream_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_valid (push0_valid),
        .push_ready (push0_ready),
        .push_data  (I_data),
        .pop_valid  (O0_valid),
        .pop_ready  (O0_ready),
        .pop_data   (O0_data)
    );

    stream_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_valid (push1_valid),
        .push_ready (push1_ready),
        .push_data  (I_data),
        .pop_valid  (O1_valid),
        .pop_ready  (O1_ready),
        .pop_data   (O1_data)
    );

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed scenarios plus random traffic against a queue-based model.
module tb_demux2_stream;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         I_valid;
    logic         I_ready;
    logic [W-1:0] I_data;
    logic         I_sel;
    logic         O0_valid;
    logic         O0_ready;
    logic [W-1:0] O0_data;
    logic         O1_valid;
    logic         O1_ready;
    logic [W-1:0] O1_data;

    int total = 0;
    int bad   = 0;

    // Reference model: contents of each output buffer, oldest first.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 CLK = ~CLK;

    demux2_stream #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .I_valid  (I_valid),
        .I_ready  (I_ready),
        .I_data   (I_data),
        .I_sel    (I_sel),
        .O0_valid (O0_valid),
        .O0_ready (O0_ready),
        .O0_data  (O0_data),
        .O1_valid (O1_valid),
        .O1_ready (O1_ready),
        .O1_data  (O1_data)
    );

    task automatic set_in(input logic rst, input logic v, input logic sel,
                          input logic [W-1:0] d, input logic r0, input logic r1);
        RESET    = rst;
        I_valid  = v;
        I_sel    = sel;
        I_data   = d;
        O0_ready = r0;
        O1_ready = r1;
        #1;
    endtask

    // Advance one clock edge and apply the handshake rules to the model.
    task automatic tick();
        bit acc;
        bit p0;
        bit p1;
        acc = !RESET && I_valid && ((I_sel ? q1.size() : q0.size()) < 2);
        p0  = !RESET && O0_ready && (q0.size() != 0);
        p1  = !RESET && O1_ready && (q1.size() != 0);
        @(posedge CLK);
        if (RESET) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc) begin
                if (I_sel) q1.push_back(I_data);
                else       q0.push_back(I_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 8'h5A, 1, 1);
        tick();
        tick();
        set_in(0, 0, 0, 8'h00, 0, 0);
        total++; if (O0_valid !== 1'b0) begin bad++; $display("FAIL reset_o0_valid got=%b want=0", O0_valid); end
        total++; if (O1_valid !== 1'b0) begin bad++; $display("FAIL reset_o1_valid got=%b want=0", O1_valid); end
        total++; if (O0_data !== 8'h00) begin bad++; $display("FAIL reset_o0_data got=%h want=00", O0_data); end
        total++; if (O1_data !== 8'h00) begin bad++; $display("FAIL reset_o1_data got=%h want=00", O1_data); end
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_sel0 got=%b want=1", I_ready); end
        set_in(0, 0, 1, 8'h00, 0, 0);
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_sel1 got=%b want=1", I_ready); end
        tick();
    endtask

    task automatic test_basic();
        set_in(0, 1, 0, 8'h11, 1, 1);
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL basic_ready0 got=%b want=1", I_ready); end
        tick();
        set_in(0, 1, 1, 8'h22, 1, 1);
        total++; if (O0_valid !== 1'b1 || O0_data !== 8'h11) begin bad++; $display("FAIL basic_o0_first got=%b/%h want=1/11", O0_valid, O0_data); end
        total++; if (O1_valid !== 1'b0) begin bad++; $display("FAIL basic_o1_idle got=%b want=0", O1_valid); end
        tick();
        set_in(0, 1, 0, 8'h33, 1, 1);
        total++; if (O1_valid !== 1'b1 || O1_data !== 8'h22) begin bad++; $display("FAIL basic_o1_word got=%b/%h want=1/22", O1_valid, O1_data); end
        total++; if (O0_valid !== 1'b0) begin bad++; $display("FAIL basic_o0_drained got=%b want=0", O0_valid); end
        tick();
        set_in(0, 0, 0, 8'h00, 1, 1);
        total++; if (O0_valid !== 1'b1 || O0_data !== 8'h33) begin bad++; $display("FAIL basic_o0_second got=%b/%h want=1/33", O0_valid, O0_data); end
        total++; if (O1_valid !== 1'b0) begin bad++; $display("FAIL basic_o1_drained got=%b want=0", O1_valid); end
        tick();
        total++; if (O0_valid !== 1'b0) begin bad++; $display("FAIL basic_o0_empty got=%b want=0", O0_valid); end
    endtask

    task automatic test_stall();
        set_in(0, 1, 0, 8'hA1, 0, 1);
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_a1 got=%b want=1", I_ready); end
        tick();
        set_in(0, 1, 0, 8'hA2, 0, 1);
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_a2 got=%b want=1", I_ready); end
        tick();
        set_in(0, 1, 0, 8'hA3, 0, 1);
        total++; if (I_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_full got=%b want=0", I_ready); end
        tick();
        set_in(0, 1, 1, 8'hB1, 0, 1);
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL stall_other_ready got=%b want=1", I_ready); end
        tick();
        set_in(0, 0, 0, 8'h00, 0, 1);
        total++; if (O1_valid !== 1'b1 || O1_data !== 8'hB1) begin bad++; $display("FAIL stall_other_word got=%b/%h want=1/b1", O1_valid, O1_data); end
        total++; if (O0_valid !== 1'b1 || O0_data !== 8'hA1) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/a1", O0_valid, O0_data); end
        tick();
        set_in(0, 1, 0, 8'hA3, 1, 1);
        total++; if (I_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b want=0", I_ready); end
        total++; if (O0_data !== 8'hA1) begin bad++; $display("FAIL full_pop_word got=%h want=a1", O0_data); end
        tick();
        set_in(0, 1, 0, 8'hA3, 1, 1);
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL full_retry_ready got=%b want=1", I_ready); end
        total++; if (O0_data !== 8'hA2) begin bad++; $display("FAIL full_second_word got=%h want=a2", O0_data); end
        tick();
        set_in(0, 0, 0, 8'h00, 1, 1);
        total++; if (O0_valid !== 1'b1 || O0_data !== 8'hA3) begin bad++; $display("FAIL full_third_word got=%b/%h want=1/a3", O0_valid, O0_data); end
        tick();
        total++; if (O0_valid !== 1'b0) begin bad++; $display("FAIL stall_end_empty got=%b want=0", O0_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            set_in(0, 1, 0, W'(i), 1, 1);
            total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, I_ready); end
            if (i > 0) begin
                total++;
                if (O0_valid !== 1'b1 || O0_data !== W'(i - 1)) begin
                    bad++; $display("FAIL b2b_word[%0d] got=%b/%h want=1/%h", i, O0_valid, O0_data, W'(i - 1));
                end
            end
            tick();
        end
        set_in(0, 0, 0, 8'h00, 1, 1);
        total++; if (O0_valid !== 1'b1 || O0_data !== 8'h0F) begin bad++; $display("FAIL b2b_last got=%b/%h want=1/0f", O0_valid, O0_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(0, 1, 0, 8'hC1, 0, 0);
        tick();
        set_in(0, 1, 1, 8'hC2, 0, 0);
        tick();
        set_in(1, 1, 0, 8'hC3, 1, 1);
        total++; if (O0_valid !== 1'b1 || O1_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b%b want=11", O0_valid, O1_valid); end
        tick();
        set_in(0, 0, 0, 8'h00, 1, 1);
        total++; if (O0_valid !== 1'b0 || O1_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b%b want=00", O0_valid, O1_valid); end
        total++; if (O0_data !== 8'h00 || O1_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h/%h want=00/00", O0_data, O1_data); end
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", I_ready); end
        tick();
        tick();
        total++; if (O0_valid !== 1'b0 || O1_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_ghost got=%b%b want=00", O0_valid, O1_valid); end
    endtask

    task automatic test_random();
        logic exp_ready;
        for (int n = 0; n < 500; n++) begin
            set_in(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), W'($urandom),
                   ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
            exp_ready = ((I_sel ? q1.size() : q0.size()) < 2);
            total++;
            if (I_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", n, I_ready, exp_ready); end
            total++;
            if (O0_valid !== (q0.size() != 0) || (q0.size() != 0 && O0_data !== q0[0])) begin
                bad++; $display("FAIL rnd_o0[%0d] got=%b/%h want=%b/%h", n, O0_valid, O0_data, q0.size() != 0, (q0.size() != 0) ? q0[0] : 8'h00);
            end
            total++;
            if (O1_valid !== (q1.size() != 0) || (q1.size() != 0 && O1_data !== q1[0])) begin
                bad++; $display("FAIL rnd_o1[%0d] got=%b/%h want=%b/%h", n, O1_valid, O1_data, q1.size() != 0, (q1.size() != 0) ? q1[0] : 8'h00);
            end
            tick();
        end
    endtask

    initial begin
        RESET    = 1'b1;
        I_valid  = 1'b0;
        I_sel    = 1'b0;
        I_data   = '0;
        O0_ready = 1'b0;
        O1_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter: WIDTH, default 1, data width in bits of every data port; SHALL be legal for any value >= 1.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 I_valid  input  1  upstream word present.
REQ-005 I_ready  output  1  block accepts the upstream word this cycle.
REQ-006 I_data  input  WIDTH  upstream word.
REQ-007 I_sel  input  1  destination of the upstream word: 0 routes to O0, 1 routes to O1; qualified by I_valid.
REQ-008 O0_valid / O1_valid  output  1 each  output stream word present.
REQ-009 O0_ready / O1_ready  input  1 each  downstream accepts the word.
REQ-010 O0_data / O1_data  output  WIDTH each  output stream word.

Function
REQ-011 A transfer occurs on any port in a cycle where its valid and ready are both 1 at the rising CLK edge; the block SHALL never drop, duplicate or reorder words within one output stream.
REQ-012 Each output SHALL own an independent 2-entry FIFO; count per FIFO ranges 0..2.
REQ-013 I_ready SHALL equal (count of FIFO[I_sel] < 2); it SHALL depend combinationally only on I_sel and registered state, never on O0_ready/O1_ready.
REQ-014 An accepted input SHALL push I_data into FIFO[I_sel] only; the other FIFO SHALL be unaffected.
REQ-015 Ox_valid SHALL equal (count_x != 0); Ox_data SHALL present the oldest entry of FIFO x, driven from registers.
REQ-016 Latency: a word accepted at edge t SHALL appear on Ox_valid/Ox_data after edge t, i.e. in cycle t+1, when FIFO x was empty.
REQ-017 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and preserve order; legal when count is 1.
REQ-018 Full FIFO (count 2): I_ready SHALL be 0 for that selection even if Ox_ready is 1 in the same cycle; the pop still occurs.
REQ-019 Sustained throughput SHALL be one word per cycle per output when downstream ready is held 1.
REQ-020 Downstream stall on one output SHALL NOT block input words selected for the other output.
REQ-021 Ox_data SHALL hold stable while Ox_valid = 1 and Ox_ready = 0.
REQ-022 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-023 While RESET = 1 at a rising edge, both FIFOs SHALL be emptied (count 0, pointers 0) regardless of concurrent handshakes; accepted-but-unread data is discarded.
REQ-024 Output values after reset: O0_valid = 0, O1_valid = 0, I_ready = 1; O0_data/O1_data SHALL be 0.
REQ-025 Reset asserted mid-transfer SHALL take priority over push and pop in that cycle.

Structure
REQ-026 A shared package SHALL hold constant FIFO_DEPTH = 2 and the count type (2 bits).
REQ-027 One sub-module, stream_fifo2 (2-entry valid/ready FIFO, parameter WIDTH, ports CLK, RESET), SHALL be instantiated twice; top level holds only routing and I_ready selection.

Verification
REQ-028 Reset then idle -> O0_valid = O1_valid = 0, I_ready = 1 for both I_sel values.
REQ-029 WIDTH=8, both Ox_ready = 1, push 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0) on consecutive cycles -> O0 emits 0x11 then 0x33, O1 emits 0x22, each one cycle after acceptance.
REQ-030 O0_ready = 0, push 0xA1, 0xA2, 0xA3 to sel 0 -> first two accepted, I_ready = 0 on third; pushes with sel 1 still accepted and delivered on O1.
REQ-031 FIFO0 full, O0_ready = 1 and I_valid = 1 with sel 0 in same cycle -> 0xA1 popped, no push; next cycle 0xA3 accepted; O0 order 0xA1, 0xA2, 0xA3.
REQ-032 Continuous sel 0 stream of 0x00..0x0F with O0_ready = 1 -> 16 words in 16 consecutive cycles, in order, no bubbles.
REQ-033 Both FIFOs holding data, RESET pulsed 1 cycle during an active push -> both Ox_valid = 0 next cycle, pushed word not delivered.
